// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared constants, scan classification types and classifier
//             for the 4x4 keypad scanner.
//  Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int KP_ROWS   = 4;
    localparam int KP_COLS   = 4;
    localparam int KP_CODE_W = 4;
    localparam int KP_KEYS   = KP_ROWS * KP_COLS;

    typedef enum logic [1:0] {
        KP_NONE   = 2'd0,
        KP_SINGLE = 2'd1,
        KP_MULTI  = 2'd2
    } kp_class_t;

    // idx is forced to zero for NONE/MULTI so whole-struct equality is meaningful
    typedef struct packed {
        kp_class_t              cls;
        logic [KP_CODE_W-1:0]   idx;
    } kp_scan_t;

    function automatic kp_scan_t kp_classify(input logic [KP_KEYS-1:0] vec);
        kp_scan_t   res;
        logic [4:0] ones;
        res.cls = KP_NONE;
        res.idx = '0;
        ones    = '0;
        for (int i = 0; i < KP_KEYS; i++) begin
            if (vec[i]) begin
                ones    = ones + 5'd1;
                res.idx = KP_CODE_W'(i);
            end
        end
        if (ones == 5'd1) begin
            res.cls = KP_SINGLE;
        end else if (ones != 5'd0) begin
            res.cls = KP_MULTI;
            res.idx = '0;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_debounce
//  Purpose  : Classifies each completed scan, requires DEBOUNCE_SCANS equal
//             results in a row, and reports committed-state changes.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_scan_done,
    input  logic [KP_KEYS-1:0]   i_scan_vec,
    output logic [KP_CODE_W-1:0] o_key_code,
    output logic                 o_key_valid,
    output logic                 o_key_release,
    output logic                 o_key_down,
    output logic                 o_multi_key
);

    localparam logic [7:0] c_db_max    = 8'(DEBOUNCE_SCANS);
    localparam kp_scan_t   c_scan_none = '{cls: KP_NONE, idx: '0};

    kp_scan_t               w_cls;
    kp_scan_t               r_prev,    w_prev_nxt;
    kp_scan_t               r_state,   w_state_nxt;
    logic [7:0]             r_count,   w_count_nxt;
    logic [KP_CODE_W-1:0]   r_code,    w_code_nxt;
    logic                   r_valid,   w_valid_nxt;
    logic                   r_release, w_release_nxt;
    logic                   r_down,    w_down_nxt;
    logic                   r_multi,   w_multi_nxt;

    assign w_cls = kp_classify(i_scan_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev    <= c_scan_none;
            r_state   <= c_scan_none;
            r_count   <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_release <= 1'b0;
            r_down    <= 1'b0;
            r_multi   <= 1'b0;
        end else begin
            r_prev    <= w_prev_nxt;
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_code    <= w_code_nxt;
            r_valid   <= w_valid_nxt;
            r_release <= w_release_nxt;
            r_down    <= w_down_nxt;
            r_multi   <= w_multi_nxt;
        end
    end

    always_comb begin
        w_prev_nxt    = r_prev;
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_code_nxt    = r_code;
        w_down_nxt    = r_down;
        w_multi_nxt   = r_multi;
        w_valid_nxt   = 1'b0;
        w_release_nxt = 1'b0;

        if (i_scan_done) begin
            w_prev_nxt = w_cls;
            if (w_cls == r_prev) begin
                w_count_nxt = (r_count >= c_db_max) ? c_db_max : r_count + 8'd1;
            end else begin
                w_count_nxt = 8'd1;
            end

            if ((w_count_nxt == c_db_max) && (w_cls != r_state)) begin
                w_state_nxt = w_cls;
                case (w_cls.cls)
                    KP_SINGLE: begin
                        w_code_nxt  = w_cls.idx;
                        w_down_nxt  = 1'b1;
                        w_multi_nxt = 1'b0;
                        w_valid_nxt = 1'b1;
                    end
                    KP_MULTI: begin
                        w_down_nxt    = 1'b0;
                        w_multi_nxt   = 1'b1;
                        w_release_nxt = (r_state.cls == KP_SINGLE);
                    end
                    default: begin
                        w_down_nxt    = 1'b0;
                        w_multi_nxt   = 1'b0;
                        w_release_nxt = (r_state.cls == KP_SINGLE);
                    end
                endcase
            end
        end
    end

    assign o_key_code    = r_code;
    assign o_key_valid   = r_valid;
    assign o_key_release = r_release;
    assign o_key_down    = r_down;
    assign o_multi_key   = r_multi;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : 4x4 keypad row scanner with column synchroniser, scan-vector
//             assembly and whole-scan debouncing.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic                 hwclk,
    input  logic                 hwrst_n,
    output logic [KP_ROWS-1:0]   keypad_r,
    input  logic [KP_COLS-1:0]   keypad_c,
    output logic [KP_CODE_W-1:0] key_code,
    output logic                 key_valid,
    output logic                 key_release,
    output logic                 key_down,
    output logic                 multi_key
);

    localparam int                    c_dwell_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_dwell_w-1:0]  c_dwell_last = c_dwell_w'(SCAN_DIV - 1);
    localparam logic [1:0]            c_last_row   = 2'(KP_ROWS - 1);

    logic                   r_active;
    logic [1:0]             r_row;
    logic [c_dwell_w-1:0]   r_dwell;
    logic [KP_ROWS-1:0]     r_rows;
    logic [KP_COLS-1:0]     r_sync1;
    logic [KP_COLS-1:0]     r_sync2;
    logic [KP_KEYS-1:0]     r_vec;
    logic [KP_KEYS-1:0]     w_vec_full;
    logic                   w_sample;
    logic                   w_scan_done;

    assign w_sample    = r_active && (r_dwell == c_dwell_last);
    assign w_scan_done = w_sample && (r_row == c_last_row);
    assign w_vec_full  = r_vec | ({{(KP_KEYS-KP_COLS){1'b0}}, ~r_sync2} << {r_row, 2'b00});

    // First clock after reset only enables row 0 so it gets a full dwell
    always_ff @(posedge hwclk or negedge hwrst_n) begin
        if (!hwrst_n) begin
            r_active <= 1'b0;
            r_row    <= '0;
            r_dwell  <= '0;
            r_rows   <= '1;
        end else if (!r_active) begin
            r_active <= 1'b1;
            r_rows   <= 4'b1110;
        end else if (r_dwell == c_dwell_last) begin
            r_dwell  <= '0;
            r_row    <= r_row + 2'd1;
            r_rows   <= {r_rows[KP_ROWS-2:0], r_rows[KP_ROWS-1]};
        end else begin
            r_dwell  <= r_dwell + c_dwell_w'(1);
        end
    end

    always_ff @(posedge hwclk or negedge hwrst_n) begin
        if (!hwrst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= keypad_c;
            r_sync2 <= r_sync1;
        end
    end

    // The final row is merged combinationally and handed straight to the debouncer
    always_ff @(posedge hwclk or negedge hwrst_n) begin
        if (!hwrst_n) begin
            r_vec <= '0;
        end else if (w_scan_done) begin
            r_vec <= '0;
        end else if (w_sample) begin
            r_vec <= w_vec_full;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk           (hwclk),
        .rst_n         (hwrst_n),
        .i_scan_done   (w_scan_done),
        .i_scan_vec    (w_vec_full),
        .o_key_code    (key_code),
        .o_key_valid   (key_valid),
        .o_key_release (key_release),
        .o_key_down    (key_down),
        .o_multi_key   (multi_key)
    );

    assign keypad_r = r_rows;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scanner
//  Purpose  : Directed keypad scenarios checked against a cycle-indexed
//             behavioural model of the scanner.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SD = 8;
    localparam int DB = 3;

    logic        hwclk   = 1'b0;
    logic        hwrst_n = 1'b1;
    logic [3:0]  keypad_r;
    logic [3:0]  keypad_c;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_release;
    logic        key_down;
    logic        multi_key;
    logic [15:0] pressed = '0;

    int n_vec          = 0;
    int n_miss         = 0;
    int n_valid_seen   = 0;
    int n_release_seen = 0;

    always #5 hwclk = ~hwclk;

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .hwclk       (hwclk),
        .hwrst_n     (hwrst_n),
        .keypad_r    (keypad_r),
        .keypad_c    (keypad_c),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_release (key_release),
        .key_down    (key_down),
        .multi_key   (multi_key)
    );

    // Membrane: a pressed key shorts its column to a row that is driven low
    always_comb begin
        keypad_c = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!keypad_r[r] && pressed[r*4+c]) keypad_c[c] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle n after reset release drives row ((n-1)/SD)%4; the sample taken in
    // the last cycle of a row sees the pad as it was two clocks earlier.
    initial begin : model
        int         m_n, m_prev, m_cnt, m_comm, cls, row, ones;
        logic [3:0] m_r, cobs, h0, h1, h2, m_code;
        logic [15:0] m_vec;
        logic       m_valid, m_release, m_down, m_multi;
        m_n = 0; m_prev = -1; m_cnt = 0; m_comm = -1;
        m_r = 4'hF; h0 = 4'hF; h1 = 4'hF; h2 = 4'hF; m_vec = '0; m_code = '0;
        m_valid = 0; m_release = 0; m_down = 0; m_multi = 0;
        forever begin
            @(negedge hwclk);
            if (!hwrst_n) begin
                m_n = 0; m_prev = -1; m_cnt = 0; m_comm = -1;
                m_r = 4'hF; h0 = 4'hF; h1 = 4'hF; h2 = 4'hF; m_vec = '0; m_code = '0;
                m_valid = 0; m_release = 0; m_down = 0; m_multi = 0;
            end else begin
                cobs = 4'hF;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        if (!m_r[r] && pressed[r*4+c]) cobs[c] = 1'b0;
                h2 = h1; h1 = h0; h0 = cobs;
                m_n++;
                m_r = ~(4'b0001 << (((m_n - 1) / SD) % 4));
                m_valid = 0; m_release = 0;
                if (m_n >= SD + 2 && ((m_n - 2) % SD) == SD - 1) begin
                    row = ((m_n - 2) / SD) % 4;
                    m_vec[row*4 +: 4] = ~h2;
                    if (row == 3) begin
                        ones = $countones(m_vec);
                        cls = -1;
                        if (ones > 1) cls = 16;
                        else if (ones == 1)
                            for (int k = 0; k < 16; k++) if (m_vec[k]) cls = k;
                        m_cnt = (cls == m_prev) ? ((m_cnt + 1 > DB) ? DB : m_cnt + 1) : 1;
                        m_prev = cls;
                        if (m_cnt == DB && cls != m_comm) begin
                            if (cls >= 0 && cls < 16) begin
                                m_code = 4'(cls); m_down = 1; m_multi = 0; m_valid = 1;
                            end else begin
                                m_release = (m_comm >= 0 && m_comm < 16);
                                m_down = 0;
                                m_multi = (cls == 16);
                            end
                            m_comm = cls;
                        end
                        m_vec = '0;
                    end
                end
            end
            chk("keypad_r",    keypad_r,    m_r);
            chk("key_code",    key_code,    m_code);
            chk("key_valid",   key_valid,   m_valid);
            chk("key_release", key_release, m_release);
            chk("key_down",    key_down,    m_down);
            chk("multi_key",   multi_key,   m_multi);
            if (key_valid)   n_valid_seen++;
            if (key_release) n_release_seen++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge hwclk);
            #1;
        end
    endtask

    // sel: 0 = key_valid pulse, 1 = key_release pulse, 2 = multi_key level
    task automatic wait_sig(input string name, input int sel, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1);
            case (sel)
                0:       seen = key_valid;
                1:       seen = key_release;
                default: seen = multi_key;
            endcase
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    initial begin : stim
        int base_v, base_r;
        hwrst_n = 1'b0;
        pressed = '0;
        step(3);
        chk("rst_keypad_r",    keypad_r,    4'b1111);
        chk("rst_key_code",    key_code,    4'd0);
        chk("rst_key_valid",   key_valid,   1'b0);
        chk("rst_key_release", key_release, 1'b0);
        chk("rst_key_down",    key_down,    1'b0);
        chk("rst_multi_key",   multi_key,   1'b0);

        hwrst_n = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            step(1);
            if (i == 1 || i == 8) chk("row0_drive", keypad_r, 4'b1110);
            if (i == 9)           chk("row1_drive", keypad_r, 4'b1101);
            if (i == 17)          chk("row2_drive", keypad_r, 4'b1011);
            if (i == 25 || i == 32) chk("row3_drive", keypad_r, 4'b0111);
            if (i == 33)          chk("row_wrap",   keypad_r, 4'b1110);
        end

        // Single key 6 held
        base_v = n_valid_seen; base_r = n_release_seen;
        pressed[6] = 1'b1;
        wait_sig("k6_valid", 0, 4*4*SD + 3);
        chk("k6_code", key_code, 4'd6);
        chk("k6_down", key_down, 1'b1);
        step(20*4*SD);
        chk("k6_valid_once", n_valid_seen - base_v, 1);
        chk("k6_no_release", n_release_seen - base_r, 0);

        // Release, then press again
        base_v = n_valid_seen;
        pressed[6] = 1'b0;
        wait_sig("k6_release", 1, 4*4*SD + 3);
        chk("k6_rel_down", key_down, 1'b0);
        chk("k6_rel_code", key_code, 4'd6);
        chk("k6_rel_no_valid", n_valid_seen - base_v, 0);
        pressed[6] = 1'b1;
        wait_sig("k6_revalid", 0, 4*4*SD + 3);
        chk("k6_revalid_code", key_code, 4'd6);
        pressed[6] = 1'b0;
        wait_sig("k6_release2", 1, 4*4*SD + 3);

        // Bounce with a 24-cycle period never yields three equal scans
        base_v = n_valid_seen;
        for (int i = 0; i < 25; i++) begin
            pressed[6] = ~pressed[6];
            step(12);
        end
        chk("bounce_quiet", n_valid_seen - base_v, 0);
        chk("bounce_down", key_down, 1'b0);
        pressed[6] = 1'b1;
        wait_sig("bounce_valid", 0, 4*4*SD + 3);
        chk("bounce_code", key_code, 4'd6);
        step(8*SD);
        chk("bounce_valid_once", n_valid_seen - base_v, 1);
        pressed[6] = 1'b0;
        wait_sig("bounce_release", 1, 4*4*SD + 3);

        // Two keys, then drop to one, then slide to another
        base_v = n_valid_seen;
        pressed[0] = 1'b1;
        pressed[5] = 1'b1;
        wait_sig("multi_on", 2, 4*4*SD + 3);
        chk("multi_no_valid", n_valid_seen - base_v, 0);
        chk("multi_down", key_down, 1'b0);
        pressed[0] = 1'b0;
        wait_sig("multi_to_5", 0, 4*4*SD + 3);
        chk("multi_to_5_code", key_code, 4'd5);
        chk("multi_off", multi_key, 1'b0);
        base_r = n_release_seen;
        pressed[5]  = 1'b0;
        pressed[15] = 1'b1;
        wait_sig("slide_15", 0, 4*4*SD + 3);
        chk("slide_code", key_code, 4'd15);
        chk("slide_no_release", n_release_seen - base_r, 0);
        chk("slide_down", key_down, 1'b1);

        // Reset while key 15 is held
        hwrst_n = 1'b0;
        step(1);
        chk("mid_rst_keypad_r", keypad_r, 4'b1111);
        chk("mid_rst_code",     key_code, 4'd0);
        chk("mid_rst_down",     key_down, 1'b0);
        step(1);
        hwrst_n = 1'b1;
        base_v = n_valid_seen;
        wait_sig("rst_revalid", 0, 4*4*SD + 3 + 8);
        chk("rst_revalid_code", key_code, 4'd15);
        chk("rst_revalid_once", n_valid_seen - base_v, 1);

        pressed = '0;
        step(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit (t=%0t)", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
